// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer write path.
package fb_pkg;
  localparam int ADR_W = 18;
  localparam int PIX_W = 8;

  localparam logic [3:0]  FB_SEL   = 4'h1;
  localparam logic [21:0] CTRL_ADR = 22'h3FFFF0;

  // Status register bit positions; bits [1:0] carry the low queue occupancy.
  localparam int ST_OVF   = 5;
  localparam int ST_BUSY  = 4;
  localparam int ST_FULL  = 3;
  localparam int ST_EMPTY = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL_WAIT = 2'd1,
    FILL      = 2'd2
  } fbw_state_t;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [PIX_W-1:0] pix;
  } fb_req_t;
endpackage

// File: rtl/frame_buffer_writer_if.sv
// Processor memory-mapped port seen by the frame-buffer writer.
// Strobes qualify a single cycle; there is no ready/stall, so a store is taken or dropped that cycle.
interface fb_cpu_if;
  logic        cpu_we;
  logic        cpu_re;
  logic [21:0] cpu_adr;
  logic [21:0] cpu_wdata;
  logic [21:0] cpu_rdata;
  logic        cpu_hit;

  modport slave  (input cpu_we, cpu_re, cpu_adr, cpu_wdata, output cpu_rdata, cpu_hit);
  modport master (output cpu_we, cpu_re, cpu_adr, cpu_wdata, input cpu_rdata, cpu_hit);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; a pop in the same cycle frees room for a push when full.
module sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && reset) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/frame_buffer_writer.sv
// Write side of the VGA pixel RAM: queues CPU pixel stores, applies them during blanking,
// and runs a full-screen fill engine controlled through a status/control register.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int               FIFO_DEPTH = 8,
  parameter logic [ADR_W-1:0] FB_PIXELS  = 18'h3FFFF
) (
  input  logic             clk,
  input  logic             reset,
  fb_cpu_if.slave          cpu,
  input  logic [ADR_W-1:0] vga_adr,
  input  logic             vga_blank,
  output logic [ADR_W-1:0] ram_adr,
  output logic [PIX_W-1:0] ram_data,
  output logic             ram_wren,
  output fbw_state_t       state_dbg
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fbw_state_t       state, state_nxt;
  fb_req_t          push_data, head;
  logic             full, empty;
  logic [CW-1:0]    count;
  logic             pix_sel, ctrl_sel, push_req, ctrl_wr, fill_req;
  logic             pop, fill_step, ovf;
  logic [ADR_W-1:0] fill_cnt, wr_adr;
  logic [PIX_W-1:0] fill_pix;
  logic [5:0]       status;

  assign pix_sel   = (cpu.cpu_adr[21:18] == FB_SEL);
  assign ctrl_sel  = (cpu.cpu_adr == CTRL_ADR);
  assign push_req  = cpu.cpu_we && pix_sel;
  assign ctrl_wr   = cpu.cpu_we && ctrl_sel;
  assign fill_req  = ctrl_wr && cpu.cpu_wdata[8];
  assign push_data = '{adr: cpu.cpu_adr[ADR_W-1:0], pix: cpu.cpu_wdata[PIX_W-1:0]};

  sync_fifo #(.WIDTH(ADR_W + PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // RAM writes are only launched while blanked, so the scanner never sees a write cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    fill_step = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty && vga_blank;
        if (fill_req) state_nxt = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (empty) state_nxt = FILL;
        else       pop = vga_blank;
      end
      FILL: begin
        fill_step = vga_blank;
        if (vga_blank && fill_cnt == FB_PIXELS) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      fill_cnt <= '0;
      fill_pix <= '0;
      ovf      <= 1'b0;
      ram_wren <= 1'b0;
      ram_data <= '0;
      wr_adr   <= '0;
    end else begin
      state    <= state_nxt;
      ram_wren <= pop || fill_step;
      if (pop) begin
        wr_adr   <= head.adr;
        ram_data <= head.pix;
      end else if (fill_step) begin
        wr_adr   <= fill_cnt;
        ram_data <= fill_pix;
      end
      if (fill_step) fill_cnt <= (fill_cnt == FB_PIXELS) ? '0 : fill_cnt + 1'b1;
      if (state == IDLE && fill_req) fill_pix <= cpu.cpu_wdata[PIX_W-1:0];
      if (ctrl_wr && cpu.cpu_wdata[9])   ovf <= 1'b0;
      else if (push_req && full && !pop) ovf <= 1'b1;
    end
  end

  always_comb begin
    status           = '0;
    status[ST_OVF]   = ovf;
    status[ST_BUSY]  = (state != IDLE);
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[1:0]      = count[1:0];
  end

  assign cpu.cpu_rdata = (cpu.cpu_re && ctrl_sel) ? {16'b0, status} : '0;
  assign cpu.cpu_hit   = pix_sel || ctrl_sel;
  assign ram_adr       = ram_wren ? wr_adr : vga_adr;
  assign state_dbg     = state;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: decode table, directed corner sequences, random traffic vs a queue model.
module tb_frame_buffer_writer;
  import fb_pkg::*;

  localparam logic [17:0] FB_PIX_TB = 18'h001FF;
  localparam int          DEPTH     = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] vga_adr = '0;
  logic        vga_blank = 1'b0;
  logic [17:0] ram_adr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  fbw_state_t  state_dbg;

  fb_cpu_if cpu();

  frame_buffer_writer #(.FIFO_DEPTH(DEPTH), .FB_PIXELS(FB_PIX_TB)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu),
    .vga_adr   (vga_adr),
    .vga_blank (vga_blank),
    .ram_adr   (ram_adr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending store queue, fill bookkeeping, and the write expected next cycle.
  logic [25:0] mq[$];
  logic [25:0] exp_q[$];
  bit          m_ovf, m_wait, m_fill;
  int          m_idx;
  logic [7:0]  m_col;
  logic [21:0] last_rdata;

  typedef struct {
    logic [21:0] adr;
    bit          re;
    bit          hit;
    logic [21:0] rdata;
  } dec_vec_t;
  dec_vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] m_status();
    int sz;
    sz = mq.size();
    return {m_ovf, m_wait || m_fill, sz == DEPTH, sz == 0, sz[1:0]};
  endfunction

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_ovf  = 0;
    m_wait = 0;
    m_fill = 0;
    m_idx  = 0;
    m_col  = '0;
  endtask

  task automatic cycle(input bit we, input bit re, input logic [21:0] adr,
                       input logic [21:0] wdata, input bit blank);
    bit         pop, step, was_empty, idle;
    logic [5:0] st;
    cpu.cpu_we    = we;
    cpu.cpu_re    = re;
    cpu.cpu_adr   = adr;
    cpu.cpu_wdata = wdata;
    vga_blank     = blank;
    vga_adr       = 18'($urandom_range(0, 262143));
    #1;
    st         = m_status();
    last_rdata = cpu.cpu_rdata;
    if (re && adr == CTRL_ADR) check("status", cpu.cpu_rdata, {16'b0, st});
    was_empty = (mq.size() == 0);
    idle      = !m_wait && !m_fill;
    pop       = !m_fill && !was_empty && blank;
    step      = m_fill && blank;
    exp_q.delete();
    if (pop) exp_q.push_back(mq.pop_front());
    if (step) begin
      exp_q.push_back({m_idx[17:0], m_col});
      if (m_idx == int'(FB_PIX_TB)) begin
        m_fill = 0;
        m_idx  = 0;
      end else m_idx++;
    end
    if (m_wait && was_empty) begin
      m_wait = 0;
      m_fill = 1;
    end
    if (we && adr[21:18] == FB_SEL) begin
      if (mq.size() < DEPTH) mq.push_back({adr[17:0], wdata[7:0]});
      else m_ovf = 1;
    end
    if (we && adr == CTRL_ADR) begin
      if (wdata[9]) m_ovf = 0;
      if (wdata[8] && idle) begin
        m_wait = 1;
        m_col  = wdata[7:0];
      end
    end
    @(posedge clk);
    #1;
    check("ram_wren", ram_wren, exp_q.size() != 0);
    if (exp_q.size() != 0) check("ram_write", {ram_adr, ram_data}, exp_q[0]);
    else                   check("ram_adr_mux", ram_adr, vga_adr);
  endtask

  task automatic do_reset();
    cpu.cpu_we = 0;
    cpu.cpu_re = 0;
    cpu.cpu_adr = '0;
    cpu.cpu_wdata = '0;
    vga_blank = 1;
    reset = 0;
    @(posedge clk);
    #1;
    reset = 1;
    model_clear();
    check("reset_wren", ram_wren, 1'b0);
    check("reset_data", ram_data, 8'h00);
    check("reset_state", state_dbg, IDLE);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [21:0] a;
    cpu.cpu_we = 0;
    cpu.cpu_re = 0;
    cpu.cpu_adr = '0;
    cpu.cpu_wdata = '0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Address decode and status readback right after reset.
    vt[0] = '{22'h040010, 1'b1, 1'b1, 22'h0};
    vt[1] = '{22'h3FFFF0, 1'b1, 1'b1, 22'h4};
    vt[2] = '{22'h3FFFF0, 1'b0, 1'b1, 22'h0};
    vt[3] = '{22'h3FFFF1, 1'b1, 1'b0, 22'h0};
    vt[4] = '{22'h07FFFF, 1'b1, 1'b1, 22'h0};
    vt[5] = '{22'h080000, 1'b1, 1'b0, 22'h0};
    vt[6] = '{22'h000000, 1'b1, 1'b0, 22'h0};
    vt[7] = '{22'h3C0000, 1'b1, 1'b0, 22'h0};
    for (int i = 0; i < 8; i++) begin
      cpu.cpu_re  = vt[i].re;
      cpu.cpu_adr = vt[i].adr;
      #1;
      check("dec_hit", cpu.cpu_hit, vt[i].hit);
      check("dec_rdata", cpu.cpu_rdata, vt[i].rdata);
    end
    cpu.cpu_re = 0;
    @(posedge clk);
    #1;

    // Store during blanking lands two clocks later.
    cycle(1, 0, 22'h040010, 22'h0000A5, 1);
    cycle(0, 0, 22'h0, 22'h0, 1);
    check("t1_wren", ram_wren, 1'b1);
    check("t1_adr", ram_adr, 18'h00010);
    check("t1_data", ram_data, 8'hA5);

    // Store held off through 50 active cycles, written right after blank rises.
    cycle(1, 0, 22'h040010, 22'h0000A5, 0);
    repeat (50) cycle(0, 0, 22'h0, 22'h0, 0);
    cycle(0, 0, 22'h0, 22'h0, 1);
    check("t2_wren", ram_wren, 1'b1);
    check("t2_write", {ram_adr, ram_data}, {18'h00010, 8'hA5});

    // Overflow: ten stores into an eight-entry queue.
    for (int i = 0; i < 10; i++)
      cycle(1, 0, {4'h1, 18'(32'h100 + i)}, 22'($urandom_range(0, 255)), 0);
    cycle(0, 1, CTRL_ADR, 22'h0, 0);
    check("t3_status_full_ovf", last_rdata, 22'h28);
    repeat (10) cycle(0, 0, 22'h0, 22'h0, 1);
    cycle(1, 0, CTRL_ADR, 22'h200, 0);
    cycle(0, 1, CTRL_ADR, 22'h0, 0);
    check("t3_status_cleared", last_rdata, 22'h04);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) cycle(1, 0, {4'h1, 18'(32'h200 + i)}, 22'(32'h30 + i), 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, {4'h1, 18'(32'h300 + i)}, 22'(32'h60 + i), 1);
    cycle(0, 1, CTRL_ADR, 22'h0, 0);
    check("t6_status_full_no_ovf", last_rdata, 22'h08);
    repeat (10) cycle(0, 0, 22'h0, 22'h0, 1);

    // Fill with two queued pixels; a store mid-fill drains afterwards.
    cycle(1, 0, 22'h040002, 22'h11, 0);
    cycle(1, 0, 22'h040003, 22'h22, 0);
    cycle(1, 0, CTRL_ADR, 22'h1FF, 1);
    k = 0;
    while ((m_wait || m_fill || mq.size() != 0) && k < 2000) begin
      cycle(k == 50, 0, 22'h040077, 22'h5A, (k % 7) != 3);
      k++;
    end
    check("t4_fill_done", k < 2000, 1'b1);
    cycle(0, 1, CTRL_ADR, 22'h0, 1);
    check("t4_state_idle", state_dbg, IDLE);

    // Reset in the middle of a fill.
    cycle(1, 0, CTRL_ADR, 22'h1C3, 1);
    k = 0;
    while (!(m_fill && m_idx == 32'h100) && k < 1000) begin
      cycle(0, 0, 22'h0, 22'h0, 1);
      k++;
    end
    check("t5_reached_0x100", k < 1000, 1'b1);
    do_reset();
    cycle(0, 1, CTRL_ADR, 22'h0, 1);
    check("t5_status", last_rdata, 22'h04);
    repeat (20) cycle(0, 0, 22'h0, 22'h0, 1);
    check("t5_state_idle", state_dbg, IDLE);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 999);
      if (k < 450) begin
        a = {4'h1, 18'($urandom_range(0, 262143))};
        cycle(1, 0, a, 22'($urandom), $urandom_range(0, 3) != 0);
      end else if (k < 500) begin
        a = {4'($urandom_range(2, 14)), 18'($urandom_range(0, 262143))};
        cycle(1, 0, a, 22'($urandom), $urandom_range(0, 3) != 0);
      end else if (k < 560) begin
        cycle(0, 1, CTRL_ADR, 22'h0, $urandom_range(0, 3) != 0);
      end else if (k < 570) begin
        cycle(1, 0, CTRL_ADR, 22'h200, $urandom_range(0, 3) != 0);
      end else if (k < 572) begin
        cycle(1, 0, CTRL_ADR, {12'h0, 2'b01, 8'($urandom_range(0, 255))}, 1);
      end else begin
        cycle(0, 0, 22'h0, 22'h0, $urandom_range(0, 3) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
